instruction_memory: RTL and testbench
=====================================

# instruction_memory

Parametrised, byte-loadable instruction memory for the fetch stage. It supports mixed 16/32-bit (RVC) fetches at any halfword-aligned address. Storage is organised as four byte banks so a full 32-bit instruction is read in one access. Fetches are registered behind a request/valid handshake, with fault reporting and a hardware clear sequencer.

## Interface
Parameters:
- DEPTH_BYTES, 1024: total capacity in bytes; power of two, multiple of 4, at least 16.
- ADDR_W, 32: width of the fetch and write addresses.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address of the instruction (PC).
- fetch_ready  out  1  fetch can be accepted this cycle.
- fetch_valid  out  1  one-cycle pulse; result registers updated.
- read_instruction  out  32  fetched instruction; upper 16 bits are zero when compressed.
- flag_compressed  out  1  fetched instruction is 16-bit.
- fetch_fault  out  1  fetch address was illegal.
- write_enable  in  1  byte load strobe.
- write_address  in  ADDR_W  byte address for the load.
- write_data  in  8  load byte.
- clear_mem  in  1  start the clear sequence (sampled as a level).
- busy  out  1  clear sequence in progress.

## Operation
- Byte address A maps to bank A[1:0], row A[log2(DEPTH_BYTES)-1:2].
- A fetch at A reads bytes A, A+1, A+2 and A+3, each modulo DEPTH_BYTES. This wraps from the top of memory to byte 0.
- Compressed detection: if byte A bits [1:0] != 2'b11, the instruction is compressed. Output is {16'h0, byte A+1, byte A}, flag_compressed=1.
- Otherwise the output is {A+3, A+2, A+1, A} and flag_compressed=0.
- Fault: fetch_addr[0]=1 or fetch_addr >= DEPTH_BYTES.
  - fetch_fault=1, read_instruction=0, flag_compressed=0.
  - fetch_valid still pulses.
- Loads:
  - When write_enable=1 and busy=0, write_data is written to write_address modulo DEPTH_BYTES.
  - Loads are ignored while busy=1.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_mem=1. The row counter is loaded with 0.
  - In CLEAR, all four banks write 0 at the counter row each cycle, then the counter increments.
  - CLEAR -> IDLE after row DEPTH_BYTES/4-1 is written.
  - clear_mem is ignored while in CLEAR.
- fetch_ready = !busy.
- fetch_req while busy: not accepted; no fetch_valid pulse is produced.

## Timing
- Reset values:
  - fetch_valid=0, read_instruction=0, flag_compressed=0, fetch_fault=0.
  - busy=0, FSM=IDLE, row counter=0.
  - Memory contents are not reset.
- Fetch latency 1:
  - A request accepted at edge N gives fetch_valid=1 in cycle N+1.
  - Data is stable from N+1 and held until the next accepted fetch.
  - Back-to-back fetches sustain one per cycle.
- A load and a fetch of the same byte in the same cycle: the fetch returns the old byte (read-before-write). The new byte is visible to a fetch issued on the next cycle.
- clear_mem and write_enable in the same IDLE cycle: clear wins and the load is dropped.
- clear_mem and fetch_req in the same IDLE cycle: the fetch is accepted and returns pre-clear data.
- busy=1 from the cycle after clear_mem is sampled, for exactly DEPTH_BYTES/4 cycles. busy=0 the cycle after the last row is written.
- Reset asserted mid-clear: the FSM returns to IDLE and busy=0 next cycle. Rows already cleared stay zero and the rest keep their contents.

## Configuration
- INSTR_MEM_CLEAR_EN defined: the clear FSM and row counter are built as described above.
- INSTR_MEM_CLEAR_EN undefined:
  - clear_mem is ignored.
  - busy is tied to 0 and fetch_ready is tied to 1.
  - Loads are never blocked.
  - No FSM or counter logic is synthesised.

## Structure
- Package instr_mem_pkg holds:
  - NUM_BANKS=4.
  - The clear-FSM state enum (IDLE, CLEAR).
  - RVC_OPCODE_FULL=2'b11.
  - Function is_compressed(byte) returning bit.
- Sub-module instr_mem_bank: one byte-wide bank of DEPTH_BYTES/4 rows with one synchronous write port and one synchronous read port (read-before-write). It is instantiated four times.
- The top level contains:
  - per-bank row and address generation with wrap;
  - registered A[1:0] and fault flags;
  - the output byte rotation and compressed mux;
  - the clear FSM.

## Test plan
- Load 32'h00500093 at addresses 0..3; fetch 0 -> next cycle fetch_valid=1, read_instruction=32'h00500093, flag_compressed=0.
- Load 16'h4505 at 4..5; fetch 4 -> read_instruction=32'h00004505, flag_compressed=1. Then fetch 6 holding a 32-bit instruction -> bytes 6..9 assembled correctly across the bank boundary.
- DEPTH_BYTES=1024: load 8'h93, 8'h00 at bytes 1022..1023 and 8'h50, 8'h00 at bytes 0..1; fetch 1022 -> read_instruction=32'h00500093 (wrap).
- Fetch 3 -> fetch_fault=1, read_instruction=0. Fetch 1024 -> fetch_fault=1.
- Back-to-back fetches 0, 4, 8 -> three consecutive fetch_valid pulses with the matching data. A load and a fetch to the same byte in one cycle -> the fetch returns the old value.
- With INSTR_MEM_CLEAR_EN defined, pulse clear_mem -> busy high for 256 cycles and fetch_ready=0. Loads and fetches during this window are ignored. Afterwards, fetch 0 -> 32'h00000000, flag_compressed=1. Asserting rst at cycle 100 of the clear -> busy=0 next cycle and rows 100+ are unchanged.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory: bank count, clear-FSM
// states and the RVC length-decode helper.
package instr_mem_pkg;

  localparam int NUM_BANKS = 4;

  // An instruction whose low two bits are 2'b11 is a full 32-bit encoding.
  localparam logic [1:0] RVC_OPCODE_FULL = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_t;

  // The first byte of an instruction decides its length.
  function automatic bit is_compressed(input logic [7:0] first_byte);
    return first_byte[1:0] != RVC_OPCODE_FULL;
  endfunction

endpackage

// File: rtl/instr_mem_bank.sv
// One byte-wide instruction-memory bank: synchronous write port and an
// enabled, registered read port. A read and a write to the same row in one
// cycle return the old contents.
module instr_mem_bank #(
  parameter int ROWS  = 256,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ROW_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic             re,
  input  logic [ROW_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem_reg [ROWS];
  logic [7:0] rdata_reg;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Read port; holds its value until the next enabled read.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_reg <= mem_reg[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/instruction_memory.sv
// Byte-loadable instruction memory with mixed 16/32-bit fetch at any
// halfword address. Four byte banks are read in parallel; the fetched bytes
// are rotated into instruction order behind the registered bank outputs.
// Optional feature macro: INSTR_MEM_CLEAR_EN builds the hardware clear
// sequencer (clear_mem / busy). Without it clear_mem is ignored.
module instruction_memory
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       read_instruction,
  output logic              flag_compressed,
  output logic              fetch_fault,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [7:0]        write_data,
  input  logic              clear_mem,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int ROW_W = IDX_W - 2;
  localparam int ROWS  = DEPTH_BYTES / NUM_BANKS;

  logic             fetch_accept;
  logic [ROW_W-1:0] fetch_row;
  logic [1:0]       fetch_lo;
  logic             addr_fault;
  logic [ROW_W-1:0] write_row;
  logic [1:0]       write_lo;
  logic             load_ok;
  logic             clear_active;
  logic [ROW_W-1:0] clear_row;

  logic [7:0]       bank_rdata [NUM_BANKS];
  logic [7:0]       rot_byte   [NUM_BANKS];

  logic             valid_reg;
  logic [1:0]       lo_reg;
  logic             fault_reg;
  logic             data_ok_reg;

  // Upper write-address bits are dropped by the modulo wrap.
  logic             unused_bits;
  assign unused_bits = ^{clear_mem, write_address};

  assign fetch_row    = fetch_addr[IDX_W-1:2];
  assign fetch_lo     = fetch_addr[1:0];
  assign write_row    = write_address[IDX_W-1:2];
  assign write_lo     = write_address[1:0];
  assign addr_fault   = fetch_addr[0] | ((fetch_addr >> IDX_W) != '0);
  assign fetch_accept = fetch_req & fetch_ready;

`ifdef INSTR_MEM_CLEAR_EN
  clear_state_t     state_reg;
  logic [ROW_W-1:0] row_cnt_reg;
  logic             busy_reg;

  // Clear sequencer: walks every row once, zeroing all four banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      row_cnt_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clear_mem) begin
            state_reg   <= CLEAR;
            row_cnt_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        CLEAR: begin
          row_cnt_reg <= row_cnt_reg + 1'b1;
          if (row_cnt_reg == ROW_W'(ROWS - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_reg;
  // A reset landing mid-clear must not zero the row it interrupts.
  assign clear_active = (state_reg == CLEAR) & ~rst;
  assign clear_row    = row_cnt_reg;
  // A clear request in the same cycle as a load takes priority.
  assign load_ok      = ~busy_reg & ~clear_mem;
`else
  assign busy         = 1'b0;
  assign clear_active = 1'b0;
  assign clear_row    = '0;
  assign load_ok      = 1'b1;
`endif

  assign fetch_ready = ~busy;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [ROW_W-1:0] rd_row;
    logic [ROW_W-1:0] wr_row;
    logic             wr_en;
    logic [7:0]       wr_data;

    // Banks below the start lane hold bytes of the next row (wrapping at the top).
    assign rd_row  = (2'(gi) >= fetch_lo) ? fetch_row : fetch_row + 1'b1;
    assign wr_en   = clear_active | (write_enable & load_ok & (write_lo == 2'(gi)));
    assign wr_row  = clear_active ? clear_row : write_row;
    assign wr_data = clear_active ? 8'h00 : write_data;

    instr_mem_bank #(
      .ROWS  (ROWS),
      .ROW_W (ROW_W)
    ) u_bank (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_row),
      .wdata (wr_data),
      .re    (fetch_accept),
      .raddr (rd_row),
      .rdata (bank_rdata[gi])
    );

    // Instruction byte gi comes from the bank that is gi lanes past the start lane.
    assign rot_byte[gi] = bank_rdata[lo_reg + 2'(gi)];
  end

  // Fetch-side state captured with each accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      lo_reg      <= 2'b00;
      fault_reg   <= 1'b0;
      data_ok_reg <= 1'b0;
    end else begin
      valid_reg <= fetch_accept;
      if (fetch_accept) begin
        lo_reg      <= fetch_lo;
        fault_reg   <= addr_fault;
        data_ok_reg <= 1'b1;
      end
    end
  end

  // Assemble the instruction; zero before the first fetch and on a fault.
  always_comb begin
    read_instruction = '0;
    flag_compressed  = 1'b0;
    if (data_ok_reg && !fault_reg) begin
      if (is_compressed(rot_byte[0])) begin
        read_instruction = {16'h0000, rot_byte[1], rot_byte[0]};
        flag_compressed  = 1'b1;
      end else begin
        read_instruction = {rot_byte[3], rot_byte[2], rot_byte[1], rot_byte[0]};
      end
    end
  end

  assign fetch_valid = valid_reg;
  assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory (DEPTH_BYTES=1024, ADDR_W=32).
module tb_instruction_memory;

  localparam int DEPTH = 1024;
  localparam int ROWS  = DEPTH / 4;
`ifdef INSTR_MEM_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] read_instruction;
  logic        flag_compressed;
  logic        fetch_fault;
  logic        write_enable = 1'b0;
  logic [31:0] write_address = '0;
  logic [7:0]  write_data = '0;
  logic        clear_mem = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  instruction_memory #(
    .DEPTH_BYTES (DEPTH),
    .ADDR_W      (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_ready      (fetch_ready),
    .fetch_valid      (fetch_valid),
    .read_instruction (read_instruction),
    .flag_compressed  (flag_compressed),
    .fetch_fault      (fetch_fault),
    .write_enable     (write_enable),
    .write_address    (write_address),
    .write_data       (write_data),
    .clear_mem        (clear_mem),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mem_model [DEPTH];
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic        m_comp = 1'b0;
  logic        m_fault = 1'b0;
  int          m_clear_left = 0;

  // {fault, compressed, instruction} for a fetch at byte address a.
  function automatic logic [33:0] model_fetch(input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    if (a[0] || a >= 32'(DEPTH)) return {1'b1, 1'b0, 32'h0};
    b0 = mem_model[a % DEPTH];
    b1 = mem_model[(a + 1) % DEPTH];
    b2 = mem_model[(a + 2) % DEPTH];
    b3 = mem_model[(a + 3) % DEPTH];
    if (b0[1:0] != 2'b11) return {1'b0, 1'b1, 16'h0, b1, b0};
    return {2'b00, b3, b2, b1, b0};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid      <= 1'b0;
      m_instr      <= '0;
      m_comp       <= 1'b0;
      m_fault      <= 1'b0;
      m_clear_left <= 0;
    end else begin
      m_valid <= fetch_req && (m_clear_left == 0);
      if (fetch_req && m_clear_left == 0)
        {m_fault, m_comp, m_instr} <= model_fetch(fetch_addr);
      if (m_clear_left > 0) begin
        for (int k = 0; k < 4; k++) mem_model[(ROWS - m_clear_left) * 4 + k] <= 8'h00;
        m_clear_left <= m_clear_left - 1;
      end else if (CLEAR_EN && clear_mem) begin
        m_clear_left <= ROWS;
      end else if (write_enable) begin
        mem_model[write_address % DEPTH] <= write_data;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", {31'b0, fetch_valid}, {31'b0, m_valid});
      check("instr", read_instruction, m_instr);
      check("compressed", {31'b0, flag_compressed}, {31'b0, m_comp});
      check("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      check("busy", {31'b0, busy}, {31'b0, (m_clear_left > 0)});
      check("ready", {31'b0, fetch_ready}, {31'b0, (m_clear_left == 0)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input int addr, input logic [7:0] data);
    write_enable = 1'b1; write_address = 32'(addr); write_data = data;
    step();
    write_enable = 1'b0;
    $display("load  addr=%0d data=%h", addr, data);
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) load((addr + k) % DEPTH, w[8*k +: 8]);
  endtask

  task automatic fetch(input int addr);
    fetch_req = 1'b1; fetch_addr = 32'(addr);
    step();
    fetch_req = 1'b0;
    $display("fetch addr=%0d valid=%0b instr=%h comp=%0b fault=%0b",
             addr, fetch_valid, read_instruction, flag_compressed, fetch_fault);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    step(); step();
    chk_en = 1'b1;
    check("rst_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_instr", read_instruction, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;

    // Fill the whole memory so every byte has a known value.
    for (int i = 0; i < DEPTH; i++) begin
      write_enable = 1'b1; write_address = 32'(i); write_data = 8'(i * 13 + 7);
      step();
    end
    write_enable = 1'b0;

    load_word(0, 32'h00500093);
    fetch(0);
    check("f0_valid", {31'b0, fetch_valid}, 32'd1);
    check("f0_instr", read_instruction, 32'h00500093);
    check("f0_comp", {31'b0, flag_compressed}, 32'd0);

    load(4, 8'h05); load(5, 8'h45);
    fetch(4);
    check("f4_instr", read_instruction, 32'h00004505);
    check("f4_comp", {31'b0, flag_compressed}, 32'd1);

    load_word(6, 32'h00A00113);
    fetch(6);
    check("f6_instr", read_instruction, 32'h00A00113);

    load(1022, 8'h93); load(1023, 8'h00); load(0, 8'h50); load(1, 8'h00);
    fetch(1022);
    check("wrap_instr", read_instruction, 32'h00500093);

    fetch(3);
    check("f3_fault", {31'b0, fetch_fault}, 32'd1);
    check("f3_instr", read_instruction, 32'h0);
    fetch(1024);
    check("f1024_fault", {31'b0, fetch_fault}, 32'd1);

    // Back-to-back fetches 0, 4, 8.
    load_word(0, 32'h00500093);
    fetch_req = 1'b1;
    fetch_addr = 32'd0; step();
    check("b2b0", read_instruction, 32'h00500093);
    fetch_addr = 32'd4; step();
    check("b2b4", read_instruction, 32'h00004505);
    fetch_addr = 32'd8; step();
    check("b2b8", read_instruction, 32'h000000A0);
    check("b2b8_valid", {31'b0, fetch_valid}, 32'd1);
    fetch_req = 1'b0;

    // Same-cycle load and fetch of byte 4: old byte returned.
    write_enable = 1'b1; write_address = 32'd4; write_data = 8'h13;
    fetch(4);
    write_enable = 1'b0;
    check("rbw_old", read_instruction, 32'h00004505);
    fetch(4);
    check("rbw_new", read_instruction, 32'h01134513);
    step();
    check("held_valid", {31'b0, fetch_valid}, 32'd0);
    check("held_instr", read_instruction, 32'h01134513);

`ifdef INSTR_MEM_CLEAR_EN
    // Full clear, started together with a fetch that sees pre-clear data.
    clear_mem = 1'b1;
    fetch(0);
    clear_mem = 1'b0;
    check("clr_prefetch", read_instruction, 32'h00500093);
    check("clr_busy", {31'b0, busy}, 32'd1);
    check("clr_ready", {31'b0, fetch_ready}, 32'd0);
    n = 0;
    while (busy && n < 400) begin
      write_enable = 1'b1; write_address = 32'd0; write_data = 8'hFF;
      fetch_req = 1'b1; fetch_addr = 32'd0;
      step();
      n++;
    end
    write_enable = 1'b0; fetch_req = 1'b0;
    $display("clear busy_cycles=%0d", n);
    check("clr_len", 32'(n), 32'd256);
    fetch(0);
    check("clr_f0", read_instruction, 32'h00000000);
    check("clr_f0_comp", {31'b0, flag_compressed}, 32'd1);

    // Reset in the middle of a clear.
    load_word(396, 32'h00500093);
    load_word(400, 32'h00500093);
    load_word(900, 32'h00500093);
    clear_mem = 1'b1; write_enable = 1'b1; write_address = 32'd900; write_data = 8'h77;
    step();
    clear_mem = 1'b0; write_enable = 1'b0;
    for (int i = 0; i < 100; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    fetch(396);
    check("mid_row99", read_instruction, 32'h00000000);
    fetch(400);
    check("mid_row100", read_instruction, 32'h00500093);
    fetch(900);
    check("mid_row225", read_instruction, 32'h00500093);
`else
    // Without the clear feature, clear_mem is inert and loads proceed.
    clear_mem = 1'b1;
    load(12, 8'h11);
    clear_mem = 1'b0;
    check("noclr_busy", {31'b0, busy}, 32'd0);
    check("noclr_ready", {31'b0, fetch_ready}, 32'd1);
    load(13, 8'h22);
    fetch(12);
    check("noclr_f12", read_instruction, 32'h00002211);
    check("noclr_comp", {31'b0, flag_compressed}, 32'd1);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
